fifo_burst_reader: RTL and testbench
====================================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the FIFO data and stream data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, the depth of the upstream FWFT FIFO.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(FIFO_DEPTH), the FIFO address width; the count is ADDR_WIDTH+1 bits.
REQ-004 SHALL have parameter BURST_LEN, default 4, beats per full burst, legal range 1..FIFO_DEPTH.
REQ-005 SHALL have parameter TIMEOUT, default 16, idle cycles before a partial-burst flush, minimum 2.
REQ-006 SHALL have port clk, input, 1 bit, clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-008 SHALL have port fifo_rdata_i, input, DATA_WIDTH bits, FWFT head data, valid whenever fifo_empty_i=0.
REQ-009 SHALL have port fifo_empty_i, input, 1 bit, FIFO empty flag.
REQ-010 SHALL have port fifo_count_i, input, ADDR_WIDTH+1 bits, FIFO occupancy.
REQ-011 SHALL have port fifo_ren_o, output, 1 bit, pop strobe; pops the head on the same edge.
REQ-012 SHALL have port m_valid_o, output, 1 bit, downstream beat valid.
REQ-013 SHALL have port m_ready_i, input, 1 bit, downstream ready.
REQ-014 SHALL have port m_data_o, output, DATA_WIDTH bits, beat data.
REQ-015 SHALL have port m_last_o, output, 1 bit, final beat of the current burst.
REQ-016 SHALL have port busy_o, output, 1 bit, high when the state is not IDLE.

Function
REQ-017 SHALL implement an FSM with states IDLE, BURST and DRAIN.
REQ-018 In IDLE, SHALL latch len=BURST_LEN and enter BURST when fifo_count_i>=BURST_LEN.
REQ-019 SHALL assert fifo_ren_o = (state==BURST) & ~fifo_empty_i & (pops<len) & (~m_valid_o | m_ready_i), and SHALL never assert it while fifo_empty_i=1.
REQ-020 SHALL move fifo_rdata_i on each pop into a single output register, with m_valid_o high the cycle after the pop (1-cycle latency).
REQ-021 SHALL set m_last_o with the beat whose pop brings pops==len, and SHALL hold m_last_o low otherwise.
REQ-022 SHALL enter DRAIN from BURST after the final pop, and SHALL return to IDLE when m_valid_o & m_ready_i & m_last_o.
REQ-023 SHALL hold m_data_o, m_last_o and m_valid_o stable while m_valid_o=1 and m_ready_i=0 (no beat drop, no duplicate).
REQ-024 SHALL accept a back-to-back pop and downstream accept in the same cycle, sustaining one beat per cycle with m_ready_i held at 1.
REQ-025 SHALL size the pop counter as $clog2(BURST_LEN+1) bits, clear it on entry to BURST, and increment it by one per pop with no wrap.
REQ-026 SHALL ignore changes in fifo_count_i during BURST and DRAIN; only the latched len governs the burst.

Reset
REQ-027 On rst_n=0, SHALL immediately force state=IDLE, pops=0, idle timer=0, m_valid_o=0, m_last_o=0, m_data_o=0, fifo_ren_o=0 and busy_o=0.
REQ-028 SHALL abandon a burst in progress on reset mid-burst, emitting no further beats until a new IDLE qualification occurs.

Configuration
REQ-029 SHALL support the macro FIFO_BURST_READER_TIMEOUT_EN.
REQ-030 With FIFO_BURST_READER_TIMEOUT_EN defined, SHALL count consecutive IDLE cycles with fifo_empty_i=0 and fifo_count_i<BURST_LEN.
REQ-031 With FIFO_BURST_READER_TIMEOUT_EN defined, SHALL latch len=fifo_count_i and enter BURST on the cycle the idle timer reaches TIMEOUT-1, producing a partial burst.
REQ-032 With FIFO_BURST_READER_TIMEOUT_EN defined, SHALL clear the idle timer whenever fifo_empty_i=1, on leaving IDLE, or when the full-burst condition is met (full burst takes priority).
REQ-033 Without FIFO_BURST_READER_TIMEOUT_EN, SHALL contain no timer logic and SHALL start only full BURST_LEN bursts.

Structure
REQ-034 SHALL place the FSM state enum typedef (IDLE/BURST/DRAIN) in shared package fifo_burst_pkg.
REQ-035 SHALL implement the output register/handshake as one sub-module fifo_burst_oreg (data, last, valid/ready).
REQ-036 SHALL keep all other logic in the top module.

Verification
REQ-037 SHALL verify: BURST_LEN=4, fifo_count 4, m_ready=1 -> four pops on consecutive cycles, m_valid 1 cycle later, m_last on the 4th beat, busy_o low the cycle after.
REQ-038 SHALL verify: count 3, timeout disabled -> no pops indefinitely; a 4th write -> burst starts next cycle.
REQ-039 SHALL verify: count 2, timeout enabled, TIMEOUT=16 -> burst of 2 starts after 16 idle cycles, m_last on the 2nd beat.
REQ-040 SHALL verify: m_ready toggled 1/0 during a burst with data 0xA0..0xA3 -> beats exactly 0xA0,0xA1,0xA2,0xA3 in order, held stable while stalled.
REQ-041 SHALL verify: rst_n pulsed after the 2nd beat of a burst -> all outputs 0 immediately, state IDLE, new burst of 4 from remaining data after count>=4.
REQ-042 SHALL verify: count 8, BURST_LEN=4 -> two separate bursts, each with its own m_last, at most one idle cycle between them.

Source files
------------

// File: rtl/fifo_burst_pkg.sv
// Shared types for the FIFO burst reader: the controller state encoding.
package fifo_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_burst_oreg.sv
// Single-entry output register for the burst stream: holds data/last/valid
// steady while the consumer stalls, and refills in the same cycle it drains.
module fifo_burst_oreg
  import fifo_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  last_in,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last
);

  // A load is only issued when the register is empty or being accepted,
  // so loading always wins over draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
      last  <= last_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pulls fixed-length bursts from a first-word-fall-through FIFO onto a
// valid/ready stream. Define FIFO_BURST_READER_TIMEOUT_EN for partial-burst flush.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  input  logic                  fifo_empty_i,
  input  logic [ADDR_WIDTH:0]   fifo_count_i,
  output logic                  fifo_ren_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  busy_o
);

  localparam int PW = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(BURST_LEN);
  localparam logic [PW-1:0]       FULL_LEN   = PW'(BURST_LEN);

  state_t        state, state_n;
  logic [PW-1:0] pops, pops_n;
  logic [PW-1:0] len, len_n;
  logic          last_pop;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer, timer_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer <= '0;
    else        timer <= timer_n;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pops  <= '0;
      len   <= '0;
    end else begin
      state <= state_n;
      pops  <= pops_n;
      len   <= len_n;
    end
  end

  // The burst length is latched on entry so later FIFO occupancy changes
  // cannot stretch or cut the burst in flight.
  always_comb begin
    state_n = state;
    pops_n  = pops;
    len_n   = len;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    timer_n = '0;
`endif
    fifo_ren_o = (state == BURST) && !fifo_empty_i && (pops < len) &&
                 (!m_valid_o || m_ready_i);
    last_pop   = fifo_ren_o && ((pops + PW'(1)) == len);

    case (state)
      IDLE: begin
        if (fifo_count_i >= FULL_COUNT) begin
          state_n = BURST;
          len_n   = FULL_LEN;
          pops_n  = '0;
        end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        else if (!fifo_empty_i && fifo_count_i != '0) begin
          if (timer == TIMER_LAST) begin
            state_n = BURST;
            len_n   = PW'(fifo_count_i);
            pops_n  = '0;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
`endif
      end
      BURST: begin
        if (fifo_ren_o) pops_n = pops + PW'(1);
        if (last_pop)   state_n = DRAIN;
      end
      DRAIN: begin
        if (m_valid_o && m_ready_i && m_last_o) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

  fifo_burst_oreg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_oreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (fifo_ren_o),
    .din    (fifo_rdata_i),
    .last_in(last_pop),
    .ready  (m_ready_i),
    .valid  (m_valid_o),
    .data   (m_data_o),
    .last   (m_last_o)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a queue-based FWFT FIFO model.
// Covers FIFO_BURST_READER_TIMEOUT_EN builds via a guarded partial-burst test.
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int BL = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic          fifo_ren;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(8),
    .ADDR_WIDTH(AW),
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_rdata_i(fifo_rdata),
    .fifo_empty_i(fifo_empty),
    .fifo_count_i(fifo_count),
    .fifo_ren_o  (fifo_ren),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data),
    .m_last_o    (m_last),
    .busy_o      (busy)
  );

  typedef struct {
    int            push_n;
    logic [DW-1:0] push_base;
    logic          ready;
    logic          ren;
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
    logic          busy;
  } vec_t;

  vec_t          vecs[20];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] beat_data[$];
  logic          beat_last[$];
  int            tests = 0;
  int            fails = 0;
  logic          s_ren, s_valid, s_last, s_busy;
  logic [DW-1:0] s_data;

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic refreshFifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_count = (AW + 1)'(fifo_q.size());
    fifo_rdata = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic pushData(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
  endtask

  // Sample mid-cycle; a beat is logged when it will be accepted at the next edge.
  task automatic sampleCycle();
    @(negedge clk);
    s_ren   = fifo_ren;
    s_valid = m_valid;
    s_data  = m_data;
    s_last  = m_last;
    s_busy  = busy;
    if (m_valid && m_ready) begin
      beat_data.push_back(m_data);
      beat_last.push_back(m_last);
    end
  endtask

  task automatic finishCycle();
    @(posedge clk);
    #1;
    if (s_ren) begin
      compare("pop_on_nonempty", 32'(fifo_q.size() > 0), 32'd1);
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    refreshFifo();
  endtask

  task automatic applyStimulus(input vec_t v);
    pushData(v.push_n, v.push_base);
    m_ready = v.ready;
    refreshFifo();
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    compare($sformatf("vec%0d ren", idx), 32'(s_ren), 32'(v.ren));
    compare($sformatf("vec%0d valid", idx), 32'(s_valid), 32'(v.valid));
    compare($sformatf("vec%0d last", idx), 32'(s_last), 32'(v.last));
    compare($sformatf("vec%0d busy", idx), 32'(s_busy), 32'(v.busy));
    if (v.valid) compare($sformatf("vec%0d data", idx), 32'(s_data), 32'(v.data));
  endtask

  task automatic collectBeats(input int n, input int limit);
    int c = 0;
    m_ready = 1'b1;
    while (beat_data.size() < n && c < limit) begin
      sampleCycle();
      finishCycle();
      c++;
    end
    compare("beat_count", 32'(beat_data.size()), 32'(n));
  endtask

  task automatic checkBeats(input string name, input logic [DW-1:0] base, input int n, input int per_burst);
    for (int i = 0; i < n; i++) begin
      if (i < beat_data.size()) begin
        compare($sformatf("%s data%0d", name, i), 32'(beat_data[i]), 32'(base + DW'(i)));
        compare($sformatf("%s last%0d", name, i), 32'(beat_last[i]), 32'((i % per_burst) == per_burst - 1));
      end
    end
  endtask

  task automatic checkAllZero(input string name);
    compare({name, " ren"}, 32'(fifo_ren), 32'd0);
    compare({name, " valid"}, 32'(m_valid), 32'd0);
    compare({name, " last"}, 32'(m_last), 32'd0);
    compare({name, " data"}, 32'(m_data), 32'd0);
    compare({name, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idle_cnt, c, ren_seen, idx4, idx5, gap;
    logic started;
    logic busy_hist[$];

    // Full burst with ready held high, then a burst under a stalling consumer.
    vecs[0]  = '{4, 8'h10, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[2]  = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1};
    vecs[3]  = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1};
    vecs[4]  = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1};
    vecs[5]  = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h13, 1'b1, 1'b1};
    vecs[6]  = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{4, 8'hA0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA0, 1'b0, 1'b1};
    vecs[11] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1};
    vecs[12] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1};
    vecs[13] = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b1};
    vecs[14] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1};
    vecs[15] = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b1};
    vecs[16] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b1};
    vecs[17] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b1};
    vecs[18] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b1};
    vecs[19] = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    m_ready = 1'b0;
    s_ren   = 1'b0;
    refreshFifo();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i]);
      sampleCycle();
      checkOutput(vecs[i], i);
      finishCycle();
    end

    // Eight queued entries must split into two bursts with a short gap.
    beat_data.delete();
    beat_last.delete();
    pushData(8, 8'h30);
    m_ready = 1'b1;
    refreshFifo();
    idx4 = -1;
    idx5 = -1;
    c = 0;
    while (beat_data.size() < 8 && c < 60) begin
      sampleCycle();
      busy_hist.push_back(s_busy);
      if (beat_data.size() >= 4 && idx4 < 0) idx4 = c;
      if (beat_data.size() >= 5 && idx5 < 0) idx5 = c;
      finishCycle();
      c++;
    end
    compare("two_bursts beat_count", 32'(beat_data.size()), 32'd8);
    checkBeats("two_bursts", 8'h30, 8, 4);
    gap = 0;
    if (idx4 >= 0 && idx5 > idx4)
      for (int k = idx4 + 1; k < idx5; k++) if (!busy_hist[k]) gap++;
    compare("two_bursts gap_le_1", 32'(idx5 > idx4 && gap <= 1), 32'd1);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    // Two entries below the burst threshold flush after the idle timeout.
    beat_data.delete();
    beat_last.delete();
    pushData(2, 8'h70);
    refreshFifo();
    idle_cnt = 0;
    c = 0;
    started = 1'b0;
    do begin
      sampleCycle();
      started = s_busy;
      if (!started) idle_cnt++;
      finishCycle();
      c++;
    end while (!started && c < 40);
    compare("timeout idle_cycles", 32'(idle_cnt), 32'(TO));
    compare("timeout first_ren", 32'(s_ren), 32'd1);
    collectBeats(2, 20);
    checkBeats("timeout", 8'h70, 2, 2);
`else
    // Three entries never start a burst; the fourth starts one next cycle.
    beat_data.delete();
    beat_last.delete();
    pushData(3, 8'h60);
    refreshFifo();
    ren_seen = 0;
    for (int k = 0; k < 40; k++) begin
      sampleCycle();
      if (s_ren || s_busy) ren_seen++;
      finishCycle();
    end
    compare("count3 no_activity", 32'(ren_seen), 32'd0);
    pushData(1, 8'h63);
    refreshFifo();
    sampleCycle();
    compare("count4 busy_before_edge", 32'(s_busy), 32'd0);
    finishCycle();
    sampleCycle();
    compare("count4 busy_next", 32'(s_busy), 32'd1);
    compare("count4 ren_next", 32'(s_ren), 32'd1);
    finishCycle();
    collectBeats(4, 20);
    checkBeats("count4", 8'h60, 4, 4);
`endif

    // Reset after the second beat is accepted abandons the rest of the burst.
    beat_data.delete();
    beat_last.delete();
    pushData(6, 8'h50);
    refreshFifo();
    collectBeats(2, 20);
    checkBeats("pre_reset", 8'h50, 2, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkAllZero("mid_reset");
    s_ren = 1'b0;
    finishCycle();
    sampleCycle();
    compare("in_reset busy", 32'(s_busy), 32'd0);
    compare("in_reset valid", 32'(s_valid), 32'd0);
    finishCycle();
    rst_n = 1'b1;
    beat_data.delete();
    beat_last.delete();
    ren_seen = 0;
    for (int k = 0; k < 3; k++) begin
      sampleCycle();
      if (s_ren || s_busy || s_valid) ren_seen++;
      finishCycle();
    end
    compare("post_reset count3 idle", 32'(ren_seen), 32'd0);
    pushData(1, 8'h56);
    refreshFifo();
    collectBeats(4, 20);
    checkBeats("post_reset", 8'h53, 4, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
